act_unit_pipe: RTL and testbench
================================

Name: act_unit_pipe

Overview:
- Parametrised multi-lane activation stage that succeeds the fixed 32-bit ReLU.
- Placed between the convolution/accumulate datapath and the pooling/binarize stages of the BNN accelerator.
- Applies a run-time-selectable activation to LANES signed words per beat: ReLU, leaky ReLU (shift), clipped ReLU, or sign binarize.
- Uses a 2-stage valid/ready pipeline with full backpressure, plus a saturating per-block clip/negative statistics counter.

Parameters:
- DATA_W, 32: signed word width per lane (range 8..32).
- LANES, 4: lanes processed per beat (range 1..16).
- CNT_W, 16: width of the saturating event counter.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0=ReLU, 1=leaky ReLU, 2=clipped ReLU, 3=binarize. Sampled with each accepted beat.
- leak_shift  in  5  arithmetic right shift for negatives in mode 1. Sampled with the beat.
- clip_val  in  DATA_W  signed upper clip bound for mode 2. Sampled with the beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat this cycle.
- s_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W], signed.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  LANES*DATA_W  activated lanes, same packing as s_data.
- evt_cnt  out  CNT_W  count of lanes that were zeroed, shifted or clipped. Saturates at all-ones.
- cnt_clr  in  1  synchronous clear of evt_cnt. Takes priority over increment.

Behaviour:
- Reset (rst=1 at clk edge):
  - Both stage-valid flags clear, so m_valid=0.
  - m_data=0 and evt_cnt=0.
  - s_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards all in-flight beats; no beat appears after reset unless newly accepted.
- Transfer rule: a beat moves only when valid and ready are both 1 at the edge. Both sides follow AXI-stream rules:
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- Stage 1 (S1):
  - Registers s_data, mode, leak_shift and clip_val on accept.
  - Also registers per-lane sign and the compare x > clip_val.
- Stage 2 (S2): computes the activation from the S1 registers and registers m_data.
- Stage load rules:
  - S2 loads when S2 is empty or m_ready=1.
  - S1 loads when S1 is empty or S1 moves to S2.
  - s_ready = ~v1 | ~v2 | m_ready (combinational from internal state and m_ready).
- Latency: 2 cycles from input accept to m_valid with no stall. Throughput: 1 beat/cycle sustained.
- Stalls: no bubbles are inserted while stalled and no beat is dropped or duplicated. With m_ready held at 0, exactly 2 beats are buffered and s_ready then goes low.
- Per-lane arithmetic (x signed DATA_W):
  - Mode 0: x<0 gives 0; otherwise x.
  - Mode 1: x<0 gives x >>> leak_shift (arithmetic; rounds toward -inf). A shift >= DATA_W gives -1. Otherwise x.
  - Mode 2: x<0 gives 0. x > clip_val gives clip_val. Otherwise x. If clip_val<0, every lane outputs 0.
  - Mode 3: x>=0 gives +1; x<0 gives -1 (all ones). Zero maps to +1.
  - No output ever exceeds DATA_W bits and no overflow is possible.
- Event counter:
  - Increments on each S2 load by the number of lanes in that beat that were modified. A lane is modified when its output differs from its input (x=0 in mode 3 counts).
  - Adds up to LANES per beat and saturates at 2^CNT_W-1 without wrap.
  - If cnt_clr and an increment coincide, the result is 0.

Test Plan:
1. Reset: rst high for 2 cycles with s_valid=1 -> m_valid=0, m_data=0, evt_cnt=0. After release, s_ready=1 and no output appears without a fresh beat.
2. Mode 0, LANES=4, input {5, -3, 0, 0x7FFFFFFF}, m_ready=1 -> m_data {5, 0, 0, 0x7FFFFFFF} exactly 2 cycles later; evt_cnt=1.
3. Mode 1, leak_shift=2, input {-8, -1, 12, -0x80000000} -> {-2, -1, 12, -0x20000000}. leak_shift=31 on -8 -> -1.
4. Mode 2, clip_val=6, input {7, 6, -2, 3} -> {6, 6, 0, 3}, evt_cnt+=2. clip_val=-1 -> all lanes 0.
5. Backpressure: stream 10 consecutive beats (values 1..10) with m_ready toggling 1,0,0,1,... -> s_ready drops after 2 buffered beats. Output order is 1..10 with no loss or duplicates, and m_data stays stable while stalled.
6. Counter saturation: CNT_W=4, feed mode-3 beats of all-negative lanes -> evt_cnt goes 4, 8, 12, 15, 15. cnt_clr coinciding with a beat -> 0.

Source files
------------

// File: rtl/act_unit_pipe.sv
// ----------------------------------------------------------------------------
// act_unit_pipe
//
// Multi-lane activation stage for the BNN accelerator. It sits between the
// convolution/accumulate datapath and the pooling/binarize stages. Each beat
// carries LANES signed DATA_W-bit words. Every lane gets the activation that
// was selected when the beat was accepted:
//   mode 0 : ReLU
//   mode 1 : leaky ReLU (arithmetic right shift of negatives)
//   mode 2 : clipped ReLU (upper bound clip_val)
//   mode 3 : sign binarize (+1 / -1)
//
// The block is a two-stage valid/ready pipeline with full backpressure.
//   S1 registers the beat together with its control fields and per-lane
//      pre-decoded compares.
//   S2 computes the activation and registers m_data.
// A saturating counter adds up the lanes that each beat changed.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       activation select, sampled with each accepted beat
//   leak_shift right-shift amount for negatives in mode 1, sampled with the beat
//   clip_val   signed upper clip bound for mode 2, sampled with the beat
//   s_valid    input beat valid
//   s_ready    block can accept a beat this cycle
//   s_data     input lanes, lane i at [i*DATA_W +: DATA_W]
//   m_valid    output beat valid
//   m_ready    downstream accepts the output beat
//   m_data     activated lanes, same packing as s_data
//   evt_cnt    saturating count of lanes that were zeroed, shifted or clipped
//   cnt_clr    synchronous clear of evt_cnt; takes priority over an increment
// ----------------------------------------------------------------------------
module act_unit_pipe #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [4:0]              leak_shift,
  input  logic [DATA_W-1:0]       clip_val,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]        evt_cnt,
  input  logic                    cnt_clr
);

  // The per-beat increment can be up to LANES.
  // The sum gets one extra bit so that overflow is visible before saturation.
  localparam int INC_W = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_RELU  = 2'd0,
    MODE_LEAKY = 2'd1,
    MODE_CLIP  = 2'd2,
    MODE_BIN   = 2'd3
  } mode_e;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic v1;        // S1 holds a beat
  logic v2;        // S2 (output register) holds a beat
  logic s2_load;   // S2 may take a new value at this edge
  logic s1_load;   // S1 may take a new value at this edge
  logic s1_move;   // the S1 beat advances into S2 at this edge

  // S2 is free when it is empty or its beat leaves this cycle.
  // S1 is free when it is empty or its beat advances into S2.
  // This makes s_ready equal to ~v1 | ~v2 | m_ready.
  assign s2_load = ~v2 | m_ready;
  assign s1_load = ~v1 | s2_load;
  assign s1_move = v1 & s2_load;
  assign s_ready = s1_load;
  assign m_valid = v2;

  // --------------------------------------------------------------------------
  // Stage 1 pre-decode of the incoming beat
  // --------------------------------------------------------------------------
  logic [LANES-1:0] in_neg;
  logic [LANES-1:0] in_gt_clip;

  // NOTE: every output of a combinational block gets a default at the top, so
  // that no path through the block leaves it holding its value. A path that
  // holds a value would infer a latch.
  always_comb begin
    in_neg     = '0;
    in_gt_clip = '0;
    for (int i = 0; i < LANES; i++) begin
      in_neg[i]     = s_data[i*DATA_W + DATA_W - 1];
      in_gt_clip[i] = $signed(s_data[i*DATA_W +: DATA_W]) > $signed(clip_val);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 payload registers
  // --------------------------------------------------------------------------
  logic [LANES*DATA_W-1:0] s1_data;
  mode_e                   s1_mode;
  logic [4:0]              s1_shift;
  logic [DATA_W-1:0]       s1_clip;
  logic [LANES-1:0]        s1_neg;
  logic [LANES-1:0]        s1_gt_clip;

  // NOTE: the payload registers are not reset. v1 qualifies every use of
  // them, so their content is irrelevant while the stage is empty. Leaving
  // out the reset keeps the wide data flops free of reset routing.
  always_ff @(posedge clk) begin
    if (s_valid && s1_load) begin
      s1_data    <= s_data;
      s1_mode    <= mode_e'(mode);
      s1_shift   <= leak_shift;
      s1_clip    <= clip_val;
      s1_neg     <= in_neg;
      s1_gt_clip <= in_gt_clip;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 activation and modified-lane count
  // --------------------------------------------------------------------------
  logic [LANES*DATA_W-1:0] act_data;
  logic [INC_W-1:0]        act_inc;
  logic                    clip_neg;

  // A negative clip bound forces every lane to zero in mode 2.
  assign clip_neg = s1_clip[DATA_W-1];

  // NOTE: combinational logic uses blocking '=' so that each statement sees
  // the result of the one before it within the same evaluation. Registers
  // use '<=' so that all flops update together at the edge.
  always_comb begin
    act_data = '0;
    act_inc  = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [DATA_W-1:0] x;
      logic signed [DATA_W-1:0] y;
      x = $signed(s1_data[i*DATA_W +: DATA_W]);
      y = x;
      unique case (s1_mode)
        MODE_RELU: begin
          if (s1_neg[i]) y = '0;
        end
        MODE_LEAKY: begin
          // An arithmetic shift rounds toward -inf.
          // A shift of DATA_W or more leaves only sign bits, which gives -1.
          if (s1_neg[i]) y = x >>> s1_shift;
        end
        MODE_CLIP: begin
          if (clip_neg || s1_neg[i]) y = '0;
          else if (s1_gt_clip[i])    y = $signed(s1_clip);
        end
        MODE_BIN: begin
          y = s1_neg[i] ? '1 : DATA_W'(1);
        end
        default: y = x;
      endcase
      act_data[i*DATA_W +: DATA_W] = y;
      // A lane counts as modified when its output differs from its input.
      // In mode 3 this includes x == 0, which becomes +1.
      if (y != x) act_inc = act_inc + INC_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Saturating event counter next value
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_sum  = SUM_W'(evt_cnt) + SUM_W'(act_inc);
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_data  <= '0;
      evt_cnt <= '0;
    end else begin
      if (s1_load) v1 <= s_valid;
      if (s2_load) v2 <= v1;
      // m_data changes only when a real beat moves in.
      // It therefore stays stable while the output is stalled.
      if (s1_move) m_data <= act_data;
      if (cnt_clr)      evt_cnt <= '0;
      else if (s1_move) evt_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// ----------------------------------------------------------------------------
// Testbench for act_unit_pipe (DATA_W=32, LANES=4, CNT_W=4).
// The reference model computes each lane's activation with plain integer
// arithmetic. A queue of expected output beats acts as the scoreboard.
// ----------------------------------------------------------------------------
module tb_act_unit_pipe;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;
  localparam int PW     = LANES * DATA_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic [4:0]        leak_shift;
  logic [DATA_W-1:0] clip_val;
  logic              s_valid;
  logic              s_ready;
  logic [PW-1:0]     s_data;
  logic              m_valid;
  logic              m_ready;
  logic [PW-1:0]     m_data;
  logic [CNT_W-1:0]  evt_cnt;
  logic              cnt_clr;

  always #5 clk = ~clk;

  act_unit_pipe #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .leak_shift (leak_shift),
    .clip_val   (clip_val),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .evt_cnt    (evt_cnt),
    .cnt_clr    (cnt_clr)
  );

  typedef struct packed {
    logic [PW-1:0]     data;
    logic [1:0]        mode;
    logic [4:0]        sh;
    logic [DATA_W-1:0] clip;
  } beat_t;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  int            cnt_model;
  int            n_out;
  logic          obs_mv;
  logic          obs_sr;
  logic [PW-1:0] obs_md;
  logic          prev_stall;
  beat_t         idle_b = '0;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic longint ref_act(input longint x, input int md, input int sh,
                                     input longint clip);
    longint q;
    case (md)
      0: return (x < 0) ? 0 : x;
      1: begin
        if (x >= 0) return x;
        if (sh >= DATA_W) return -1;
        q = x / (longint'(1) << sh);
        if (q * (longint'(1) << sh) != x) q = q - 1;  // floor for negatives
        return q;
      end
      2: begin
        if (clip < 0 || x < 0) return 0;
        if (x > clip) return clip;
        return x;
      end
      default: return (x < 0) ? -1 : 1;
    endcase
  endfunction

  function automatic void model_beat(input beat_t b, output logic [PW-1:0] o,
                                     output int mods);
    longint x, y, clip;
    o    = '0;
    mods = 0;
    clip = longint'($signed(b.clip));
    for (int i = 0; i < LANES; i++) begin
      x = longint'($signed(b.data[i*DATA_W +: DATA_W]));
      y = ref_act(x, int'(b.mode), int'(b.sh), clip);
      o[i*DATA_W +: DATA_W] = y[DATA_W-1:0];
      if (y != x) mods++;
    end
  endfunction

  function automatic logic [PW-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic beat_t mk(input logic [PW-1:0] d, input int md, input int sh,
                               input logic [31:0] clip);
    beat_t b;
    b.data = d;
    b.mode = 2'(md);
    b.sh   = 5'(sh);
    b.clip = clip;
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // One clock cycle: drive at negedge, sample 1 ns later, then wait for the
  // active edge. The scoreboard is checked against every visible output beat.
  // --------------------------------------------------------------------------
  task automatic drive_cycle(input beat_t b, input logic sv, input logic mr,
                             input logic clr);
    logic [PW-1:0] e;
    int            mods;
    @(negedge clk);
    s_valid    = sv;
    s_data     = b.data;
    mode       = b.mode;
    leak_shift = b.sh;
    clip_val   = b.clip;
    m_ready    = mr;
    cnt_clr    = clr;
    #1;
    obs_mv = m_valid;
    obs_sr = s_ready;
    obs_md = m_data;
    if (prev_stall) begin
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_valid: m_valid=%b while stalled, required 1", m_valid);
      end
    end
    if (m_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: m_data=%h appeared, required no beat", m_data);
      end else begin
        if (m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL out_data: m_data=%h, required %h", m_data, exp_q[0]);
        end
        if (mr) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
    prev_stall = (m_valid === 1'b1) && !mr;
    if (clr) cnt_model = 0;
    if (sv && s_ready === 1'b1) begin
      model_beat(b, e, mods);
      exp_q.push_back(e);
      cnt_model = (cnt_model + mods > CMAX) ? CMAX : cnt_model + mods;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    // Fill both stages, then reset with s_valid held high.
    drive_cycle(mk(pack4(11, 22, 33, 44), 0, 0, 0), 1'b1, 1'b0, 1'b0);
    drive_cycle(mk(pack4(55, 66, 77, 88), 0, 0, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = pack4(1, 2, 3, 4);
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid: %b, required 0", m_valid);
    end
    checks++;
    if (m_data !== '0) begin
      errors++; $display("FAIL reset_m_data: %h, required 0", m_data);
    end
    checks++;
    if (evt_cnt !== '0) begin
      errors++; $display("FAIL reset_evt_cnt: %0d, required 0", evt_cnt);
    end
    rst        = 1'b0;
    s_valid    = 1'b0;
    exp_q.delete();
    cnt_model  = 0;
    prev_stall = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: %b, required 1", s_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_mv !== 1'b0) begin
        errors++; $display("FAIL reset_no_output: m_valid=%b, required 0", obs_mv);
      end
    end
  endtask

  task automatic test_mode_relu();
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    drive_cycle(mk(pack4(5, -3, 0, 32'h7FFFFFFF), 0, 0, 0), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_mv !== 1'b0) begin
      errors++; $display("FAIL relu_latency1: m_valid=%b, required 0", obs_mv);
    end
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_mv !== 1'b1 || obs_md !== pack4(5, 0, 0, 32'h7FFFFFFF)) begin
      errors++;
      $display("FAIL relu_out: valid=%b data=%h, required 1 %h", obs_mv, obs_md,
               pack4(5, 0, 0, 32'h7FFFFFFF));
    end
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== 4'd1) begin
      errors++; $display("FAIL relu_cnt: %0d, required 1", evt_cnt);
    end
  endtask

  task automatic test_mode_leaky();
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    drive_cycle(mk(pack4(-8, -1, 12, 32'h80000000), 1, 2, 0), 1'b1, 1'b1, 1'b0);
    drive_cycle(mk(pack4(-8, -16, 100, 32'h80000000), 1, 31, 0), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_md !== pack4(-2, -1, 12, 32'hE0000000)) begin
      errors++; $display("FAIL leaky_sh2: %h, required %h", obs_md,
                         pack4(-2, -1, 12, 32'hE0000000));
    end
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_md !== pack4(-1, -1, 100, -1)) begin
      errors++; $display("FAIL leaky_sh31: %h, required %h", obs_md, pack4(-1, -1, 100, -1));
    end
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== 4'd5) begin
      errors++; $display("FAIL leaky_cnt: %0d, required 5", evt_cnt);
    end
  endtask

  task automatic test_mode_clip();
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    drive_cycle(mk(pack4(7, 6, -2, 3), 2, 0, 6), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_md !== pack4(6, 6, 0, 3)) begin
      errors++; $display("FAIL clip_pos: %h, required %h", obs_md, pack4(6, 6, 0, 3));
    end
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== 4'd2) begin
      errors++; $display("FAIL clip_cnt: %0d, required 2", evt_cnt);
    end
    drive_cycle(mk(pack4(5, -5, 0, 100), 2, 0, -1), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_md !== '0) begin
      errors++; $display("FAIL clip_neg: %h, required 0", obs_md);
    end
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== 4'd5) begin
      errors++; $display("FAIL clip_neg_cnt: %0d, required 5", evt_cnt);
    end
  endtask

  task automatic test_binarize_zero();
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    drive_cycle(mk(pack4(0, 1, -1, -7), 3, 0, 0), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_md !== pack4(1, 1, -1, -1)) begin
      errors++; $display("FAIL bin_out: %h, required %h", obs_md, pack4(1, 1, -1, -1));
    end
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== 4'd2) begin
      errors++; $display("FAIL bin_cnt: %0d, required 2", evt_cnt);
    end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   cyc  = 0;
    logic saw_low = 1'b0;
    int   out0;
    // With m_ready held low, exactly two beats are accepted.
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(mk(pack4(200 + i, 0, 0, 0), 0, 0, 0), 1'b1, 1'b0, 1'b0);
      if (obs_sr) sent++;
    end
    checks++;
    if (sent != 2 || obs_sr !== 1'b0) begin
      errors++; $display("FAIL stall_depth: accepted=%0d s_ready=%b, required 2 0", sent, obs_sr);
    end
    drain();
    // Ten beats with m_ready following 1,0,0,1,0,0,...
    sent = 0;
    out0 = n_out;
    while ((sent < 10 || exp_q.size() > 0) && cyc < 100) begin
      drive_cycle(mk(pack4(sent + 1, sent + 101, sent + 201, sent + 301), 0, 0, 0),
                  sent < 10, (cyc % 3) == 0, 1'b0);
      if (sent < 10 && obs_sr) sent++;
      if (!obs_sr) saw_low = 1'b1;
      checks++;
      if (exp_q.size() > 2) begin
        errors++; $display("FAIL bp_buffered: %0d beats held, required <= 2", exp_q.size());
      end
      cyc++;
    end
    checks++;
    if (n_out - out0 != 10) begin
      errors++; $display("FAIL bp_count: %0d beats out, required 10", n_out - out0);
    end
    checks++;
    if (!saw_low) begin
      errors++; $display("FAIL bp_s_ready: never low, required low when full");
    end
    drain();
  endtask

  task automatic test_counter_sat();
    int exp_seq[5] = '{4, 8, 12, 15, 15};
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(mk(pack4(-5, -6, -7, -100), 3, 0, 0), 1'b1, 1'b1, 1'b0);
      drain();
      @(negedge clk);
      checks++;
      if (evt_cnt !== CNT_W'(exp_seq[i])) begin
        errors++; $display("FAIL sat_step%0d: %0d, required %0d", i, evt_cnt, exp_seq[i]);
      end
    end
    // The clear lands on the same edge as this beat's S2 load.
    drive_cycle(mk(pack4(-5, -6, -7, -100), 3, 0, 0), 1'b1, 1'b1, 1'b0);
    drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
    drain();
    @(negedge clk);
    checks++;
    if (evt_cnt !== '0) begin
      errors++; $display("FAIL sat_clr_priority: %0d, required 0", evt_cnt);
    end
  endtask

  task automatic test_random();
    beat_t b;
    for (int k = 0; k < 20; k++) begin
      drive_cycle(idle_b, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 15; c++) begin
        b.mode = 2'($urandom_range(0, 3));
        b.sh   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
        case ($urandom_range(0, 2))
          0:       b.clip = 32'($urandom_range(0, 200));
          1:       b.clip = -32'($urandom_range(1, 50));
          default: b.clip = $urandom;
        endcase
        for (int i = 0; i < LANES; i++) begin
          if ($urandom_range(0, 2) == 0) b.data[i*DATA_W +: DATA_W] = $urandom;
          else b.data[i*DATA_W +: DATA_W] = 32'(int'($urandom_range(0, 600)) - 300);
        end
        drive_cycle(b, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 1'b0);
      end
      drain();
      @(negedge clk);
      checks++;
      if (evt_cnt !== CNT_W'(cnt_model)) begin
        errors++; $display("FAIL rand_cnt%0d: %0d, required %0d", k, evt_cnt, cnt_model);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    mode       = '0;
    leak_shift = '0;
    clip_val   = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_model  = 0;
    n_out      = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_mode_relu();
    test_mode_leaky();
    test_mode_clip();
    test_binarize_zero();
    test_backpressure();
    test_counter_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
